// File: rtl/palette_lut_pkg.sv
// Shared types for the palette lookup block: FSM states and the default-width RGB triple.
package palette_lut_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

endpackage

// File: rtl/palette_lut_ram.sv
// Single-clock 1W/1R palette storage with registered, read-first output.
module palette_lut_ram
    import palette_lut_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rdata_q;

    // Non-blocking update of both: a same-address access returns the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/palette_lut.sv
// Index-to-RGB palette with run-time writes and frame-synchronous colour cycling.
// Build with PALETTE_SHADOW_EN for double-buffered palette banks swapped on frame_start.
module palette_lut
    import palette_lut_pkg::*;
#(
    parameter int IDX_W     = 8,
    parameter int CH_W      = 8,
    parameter int CYCLE_DIV = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [IDX_W-1:0]    in_index,
    output logic                in_ready,
    output logic                out_valid,
    output logic [3*CH_W-1:0]   out_rgb,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_addr,
    input  logic [3*CH_W-1:0]   wr_data,
    input  logic                wr_commit,
    input  logic                frame_start,
    input  logic                cycle_en,
    output logic                busy
);

    localparam int RGB_W = 3 * CH_W;
    localparam int DEPTH = 1 << IDX_W;
    localparam int DIV_W = (CYCLE_DIV > 1) ? $clog2(CYCLE_DIV + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_ADDR = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] OFS_MAX   = IDX_W'(DEPTH - 2);
    localparam logic [IDX_W:0]   MOD_N     = (IDX_W + 1)'(DEPTH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CYCLE_DIV - 1);

    function automatic logic [CH_W-1:0] grey_chan(input logic [IDX_W-1:0] i);
        logic [IDX_W+CH_W-1:0] t;
        t = {i, {CH_W{1'b0}}};
        return t[IDX_W+CH_W-1 -: CH_W];
    endfunction

    // Rotation over entries 1..DEPTH-1 only; the sum is below 2*MOD_N so one subtract suffices.
    function automatic logic [IDX_W-1:0] map_index(input logic [IDX_W-1:0] idx,
                                                   input logic [IDX_W-1:0] ofs);
        logic [IDX_W:0] sum;
        logic [IDX_W-1:0] phys;
        sum = {1'b0, idx - IDX_W'(1)} + {1'b0, ofs};
        if (sum >= MOD_N) begin
            sum = sum - MOD_N;
        end
        phys = sum[IDX_W-1:0] + IDX_W'(1);
        if (idx == '0) begin
            phys = '0;
        end
        return phys;
    endfunction

    state_t           state_q;
    logic [IDX_W-1:0] init_addr_q;
    logic             in_ready_q;
    logic             busy_q;
    logic             run;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_addr_q <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            case (state_q)
                ST_INIT: begin
                    init_addr_q <= init_addr_q + IDX_W'(1);
                    if (init_addr_q == LAST_ADDR) begin
                        state_q    <= ST_RUN;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    assign run      = (state_q == ST_RUN);
    assign in_ready = in_ready_q;
    assign busy     = busy_q;

    logic [IDX_W-1:0] offset_q, offset_d;
    logic [DIV_W-1:0] div_q, div_d;

    always_comb begin
        offset_d = offset_q;
        div_d    = div_q;
        if (run && frame_start && cycle_en) begin
            if (div_q == DIV_LAST) begin
                div_d    = '0;
                offset_d = (offset_q == OFS_MAX) ? '0 : offset_q + IDX_W'(1);
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    logic             vld_p1_q, vld_p1_d;
    logic             vld_p2_q;
    logic [IDX_W-1:0] addr_p1_q, addr_p1_d;
    logic             wr_we_p1_q, wr_we_d;
    logic [IDX_W-1:0] wr_addr_p1_q, wr_addr_d;
    logic [RGB_W-1:0] wr_data_p1_q, wr_data_d;
    logic [RGB_W-1:0] rd_rgb;

    always_comb begin
        vld_p1_d  = in_valid & in_ready_q;
        addr_p1_d = map_index(in_index, offset_q);
        wr_we_d   = run & wr_en;
        wr_addr_d = wr_addr;
        wr_data_d = wr_data;
        if (!run) begin
            wr_we_d   = 1'b1;
            wr_addr_d = init_addr_q;
            wr_data_d = {3{grey_chan(init_addr_q)}};
        end
    end

    // Stage 1: mapped address and staged write; stage 2: RAM output.
    // Staging the write by one cycle lines it up with the RAM read of a request from the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q   <= 1'b0;
            vld_p2_q   <= 1'b0;
            wr_we_p1_q <= 1'b0;
            offset_q   <= '0;
            div_q      <= '0;
        end else begin
            vld_p1_q   <= vld_p1_d;
            vld_p2_q   <= vld_p1_q;
            wr_we_p1_q <= wr_we_d;
            offset_q   <= offset_d;
            div_q      <= div_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_p1_q    <= addr_p1_d;
        wr_addr_p1_q <= wr_addr_d;
        wr_data_p1_q <= wr_data_d;
    end

`ifdef PALETTE_SHADOW_EN
    logic             bank_q, bank_d;
    logic             swap_pending_q, swap_pending_d;
    logic             bank_p1_q, bank_p2_q;
    logic             wr_bank_p1_q, wr_both_p1_q;
    logic [RGB_W-1:0] rdata0, rdata1;

    always_comb begin
        bank_d         = bank_q;
        swap_pending_d = swap_pending_q;
        if (run) begin
            if (frame_start && (swap_pending_q || wr_commit)) begin
                bank_d         = ~bank_q;
                swap_pending_d = 1'b0;
            end else if (wr_commit) begin
                swap_pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q         <= 1'b0;
            swap_pending_q <= 1'b0;
        end else begin
            bank_q         <= bank_d;
            swap_pending_q <= swap_pending_d;
        end
    end

    // Requests carry the bank they were accepted under, so a swap never splits a lookup.
    always_ff @(posedge clk) begin
        bank_p1_q    <= bank_q;
        bank_p2_q    <= bank_p1_q;
        wr_bank_p1_q <= ~bank_q;
        wr_both_p1_q <= ~run;
    end

    palette_lut_ram #(.ADDR_W(IDX_W), .DATA_W(RGB_W)) u_ram0 (
        .clk   (clk),
        .we    (wr_we_p1_q & (wr_both_p1_q | ~wr_bank_p1_q)),
        .waddr (wr_addr_p1_q),
        .wdata (wr_data_p1_q),
        .raddr (addr_p1_q),
        .rdata (rdata0)
    );

    palette_lut_ram #(.ADDR_W(IDX_W), .DATA_W(RGB_W)) u_ram1 (
        .clk   (clk),
        .we    (wr_we_p1_q & (wr_both_p1_q | wr_bank_p1_q)),
        .waddr (wr_addr_p1_q),
        .wdata (wr_data_p1_q),
        .raddr (addr_p1_q),
        .rdata (rdata1)
    );

    assign rd_rgb = bank_p2_q ? rdata1 : rdata0;
`else
    logic unused_commit;
    assign unused_commit = wr_commit;

    palette_lut_ram #(.ADDR_W(IDX_W), .DATA_W(RGB_W)) u_ram (
        .clk   (clk),
        .we    (wr_we_p1_q),
        .waddr (wr_addr_p1_q),
        .wdata (wr_data_p1_q),
        .raddr (addr_p1_q),
        .rdata (rd_rgb)
    );
`endif

    assign out_valid = vld_p2_q;
    assign out_rgb   = vld_p2_q ? rd_rgb : '0;

endmodule

// File: tb/tb_palette_lut.sv
// Directed bench for palette_lut: scoreboard of expected colours checked against the output stream.
module tb_palette_lut;
    import palette_lut_pkg::*;

`ifdef PALETTE_SHADOW_EN
    localparam logic [23:0] E5     = 24'h050505;
    localparam logic [23:0] E6N    = 24'h060606;
    localparam logic [23:0] E3_PRE = 24'h030303;
`else
    localparam logic [23:0] E5     = 24'hFF6D66;
    localparam logic [23:0] E6N    = 24'hABCDEF;
    localparam logic [23:0] E3_PRE = 24'h123456;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_index = '0;
    logic        in_ready;
    logic        out_valid;
    logic [23:0] out_rgb;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_addr = '0;
    logic [23:0] wr_data = '0;
    logic        wr_commit = 1'b0;
    logic        frame_start = 1'b0;
    logic        cycle_en = 1'b0;
    logic        busy;

    palette_lut #(.IDX_W(8), .CH_W(8), .CYCLE_DIV(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_index    (in_index),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_rgb     (out_rgb),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_commit   (wr_commit),
        .frame_start (frame_start),
        .cycle_en    (cycle_en),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        rgb_t rgb;
        int   due;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output side of the scoreboard: every valid must match the oldest pending request, on time.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid) begin
            if (q.size() == 0) begin
                check("spurious_valid", 64'(out_valid), 64'd0);
            end else begin
                e = q.pop_front();
                check("rgb", 64'(out_rgb), 64'(e.rgb));
                check("latency", 64'(cyc), 64'(e.due));
            end
        end else if (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            check("missing_valid", 64'(out_valid), 64'd1);
        end
    end

    task automatic drive(input logic v, input logic [7:0] idx, input logic [23:0] exp,
                         input logic we, input logic [7:0] wa, input logic [23:0] wd,
                         input logic fs, input logic cm);
        exp_t e;
        in_valid    = v;
        in_index    = idx;
        wr_en       = we;
        wr_addr     = wa;
        wr_data     = wd;
        frame_start = fs;
        wr_commit   = cm;
        if (v) begin
            e.rgb = exp;
            e.due = cyc + 2;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        wr_en       = 1'b0;
        frame_start = 1'b0;
        wr_commit   = 1'b0;
    endtask

    task automatic lookup(input logic [7:0] idx, input logic [23:0] exp);
        drive(1'b1, idx, exp, 1'b0, 8'd0, 24'd0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'd0, 24'd0, 1'b0, 8'd0, 24'd0, 1'b0, 1'b0);
    endtask

    task automatic pulse();
        drive(1'b0, 8'd0, 24'd0, 1'b0, 8'd0, 24'd0, 1'b1, 1'b0);
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (busy && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 64'(n), 64'd256);
        check({tag, "_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd1);
        check("rst_ready", 64'(in_ready), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_rgb", 64'(out_rgb), 64'd0);

        rst = 1'b0;
        wait_init("init_cycles");

        // Default grey ramp
        lookup(8'h80, 24'h808080);
        lookup(8'h00, 24'h000000);
        lookup(8'hFF, 24'hFFFFFF);
        idle(1);
        lookup(8'h01, 24'h010101);
        idle(2);

        // Writes: next-cycle visibility, then same-cycle collision returns old data
        drive(1'b0, 8'd0, 24'd0, 1'b1, 8'd5, 24'hFF6D66, 1'b0, 1'b0);
        lookup(8'd5, E5);
        drive(1'b1, 8'd6, 24'h060606, 1'b1, 8'd6, 24'hABCDEF, 1'b0, 1'b0);
        lookup(8'd6, E6N);
        idle(2);

        // Colour cycling: lookup alongside frame_start still uses the old offset
        cycle_en = 1'b1;
        drive(1'b1, 8'd1, 24'h010101, 1'b0, 8'd0, 24'd0, 1'b1, 1'b0);
        lookup(8'd1, 24'h020202);
        lookup(8'd255, 24'h010101);
        lookup(8'd0, 24'h000000);
        lookup(8'd4, E5);
        lookup(8'd5, E6N);

        repeat (253) pulse();
        lookup(8'd1, 24'hFFFFFF);
        lookup(8'd2, 24'h010101);
        pulse();
        lookup(8'd1, 24'h010101);
        lookup(8'd255, 24'hFFFFFF);

        cycle_en = 1'b0;
        repeat (5) pulse();
        lookup(8'd1, 24'h010101);
        lookup(8'h80, 24'h808080);
        idle(2);

        // Commit flow: shadow builds hold the old colour until frame_start
        drive(1'b0, 8'd0, 24'd0, 1'b1, 8'd3, 24'h123456, 1'b0, 1'b0);
        drive(1'b0, 8'd0, 24'd0, 1'b0, 8'd0, 24'd0, 1'b0, 1'b1);
        lookup(8'd3, E3_PRE);
        idle(1);
        lookup(8'd3, E3_PRE);
        pulse();
        lookup(8'd3, 24'h123456);
        idle(3);

        // Leave a non-zero offset, then reset with a request in flight
        cycle_en = 1'b1;
        pulse();
        cycle_en = 1'b0;
        idle(2);
        in_valid = 1'b1;
        in_index = 8'd9;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd1);
        check("midrst_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        rst = 1'b0;
        wait_init("reinit_cycles");
        lookup(8'd3, 24'h030303);
        lookup(8'd5, 24'h050505);
        lookup(8'd6, 24'h060606);
        lookup(8'd1, 24'h010101);
        idle(4);

        check("queue_drained", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/palette_lut.md
Name: palette_lut

Overview:
- Parametrised, RAM-backed successor to the fixed index-to-RGB colour map in the Julia LCD pipeline.
- Takes an escape-count index stream from the fractal engine and returns 24-bit-class RGB to the LCD driver with fixed 2-cycle latency.
- The palette is host-writable at run time and supports frame-synchronous colour cycling (rotation of non-interior entries).
- Index 0 (interior) is never rotated.

Parameters:
- IDX_W, 8: index width; palette depth 2^IDX_W.
- CH_W, 8: bits per colour channel; rgb width 3*CH_W.
- CYCLE_DIV, 1: frame_start pulses per rotation step (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  lookup request
- in_index  in  IDX_W  palette index
- in_ready  out  1  high when lookups are accepted (RUN state)
- out_valid  out  1  result valid, 2 cycles after accepted request
- out_rgb  out  3*CH_W  {R,G,B}, R in MSBs
- wr_en  in  1  palette write strobe
- wr_addr  in  IDX_W  write address (physical entry)
- wr_data  in  3*CH_W  write colour
- wr_commit  in  1  request bank swap (shadow mode only)
- frame_start  in  1  one-cycle pulse at start of each LCD frame
- cycle_en  in  1  enable colour cycling
- busy  out  1  high during INIT

Behaviour:
- Reset values: in_ready=0, busy=1, out_valid=0, out_rgb=0, offset=0, frame divider=0, swap_pending=0, active bank=0. Reset mid-operation discards the in-flight pipeline and restarts INIT.
- INIT state:
  - Runs for 2^IDX_W cycles, sweeping addresses 0..2^IDX_W-1.
  - Writes default grey ramp: entry i = {g,g,g}, where g = i left-aligned into CH_W (zero-filled if CH_W>IDX_W, MSB-truncated otherwise). Entry 0 = 0.
  - in_ready=0 and busy=1 throughout; wr_en, wr_commit and frame_start are ignored.
  - Transitions to RUN after writing the last address.
- RUN state: in_ready=1, busy=0. Stays in RUN until reset.
- Address mapping, stage 1:
  - in_index==0 -> 0.
  - Otherwise phys = ((in_index-1+offset) mod (2^IDX_W-1)) + 1.
  - Computed without a divider: conditional subtract of 2^IDX_W-1 on the IDX_W+1-bit sum.
- RAM read, stage 2: synchronous read. out_valid(t+2) = in_valid & in_ready at t. No backpressure; out_valid drops the cycle after input gaps.
- Offset update:
  - On frame_start with cycle_en=1, increment the divider. When it reaches CYCLE_DIV, the divider goes to 0 and offset increments.
  - Offset wraps from 2^IDX_W-2 to 0.
  - cycle_en=0 holds both offset and divider.
  - Offset changes take effect only for requests accepted in the cycle after frame_start; the in-flight pipeline keeps its mapped address.
- Writes:
  - In RUN, wr_en writes wr_data to wr_addr in one cycle. wr_addr is physical and not rotated.
  - A read and write to the same entry in the same cycle returns old data (read-first).
  - Writes to entry 0 are permitted.

Optional Feature:
- Macro: PALETTE_SHADOW_EN.
- Defined:
  - Two palette banks. Lookups read the active bank; wr_en writes the shadow bank.
  - wr_commit sets swap_pending. The next frame_start toggles the active bank and clears swap_pending.
  - wr_commit coincident with frame_start swaps at that frame_start.
  - INIT fills both banks identically.
- Undefined:
  - One bank; writes go straight to the active palette.
  - wr_commit is ignored and no swap logic is generated.

Decomposition:
- Shared package holds the palette typedef (rgb_t, 3*CH_W packed struct R/G/B) and the state enum {INIT, RUN}.
- Natural sub-module: palette_ram. Single-clock simple dual-port RAM (1W/1R, read-first, registered read), parametrised on depth and width, instantiated once or twice.

Test Plan:
- Reset, then wait: busy high for exactly 256 cycles, then in_ready=1. Lookup index 0x80 -> out_rgb=0x808080 two cycles later; index 0 -> 0x000000.
- Write entry 5 = 0xFF6D66 in RUN; lookup index 5 on the next cycle -> 0xFF6D66. Same-cycle write/read of entry 6 -> old ramp value 0x060606, then the new value on the following lookup.
- cycle_en=1, CYCLE_DIV=1, one frame_start: index 1 -> entry 2 (0x020202); index 255 -> entry 1; index 0 -> entry 0.
- CYCLE_DIV=1, 254 frame_start pulses: offset wraps to 0 and index 1 -> entry 1. With cycle_en=0, pulses leave the mapping unchanged.
- Shadow build: write entry 3 = 0x123456 and pulse wr_commit. Index 3 still reads 0x030303 until frame_start, then reads 0x123456. Non-shadow build: reads 0x123456 immediately.
- Assert rst mid-stream with in_valid high: out_valid=0 the next cycle, busy=1, INIT reruns, and prior palette writes are replaced by the grey ramp.
